regfile_loop_pc_param: RTL and testbench
========================================

Name: regfile_loop_pc_param

Overview:
- Parametrised successor to the 16x16 GSU general register file.
- Holds NUM_REGS registers of DATA_W bits. Two registered read ports (x, y) and one write port (z) with independent low and high half-word lane enables.
- Built-in program-counter auto-increment and hardware loop (counter decrement plus branch-to-loop-address).
- Sits between the instruction decoder and the ALU/PLOT units of the core.

Parameters:
- DATA_W, 16, register width; must be even and >= 8.
- SEL_W, 4, select width; NUM_REGS = 2**SEL_W.
- PC_IDX, 15, index of the program-counter register.
- LCNT_IDX, 12, index of the loop-counter register.
- LADR_IDX, 13, index of the loop-address register.

Ports:
- clk  in  1  core clock; all state updates on the falling edge.
- reset  in  1  synchronous, active-low reset.
- z  in  DATA_W  write data.
- zsel  in  SEL_W  write register index.
- wr_lo  in  1  write z[DATA_W/2-1:0] into the low half of r[zsel].
- wr_hi  in  1  write z[DATA_W-1:DATA_W/2] into the high half of r[zsel].
- xsel  in  SEL_W  x read index.
- ysel  in  SEL_W  y read index.
- pcen  in  1  increment the PC.
- loopen  in  1  execute the loop step.
- x  out  DATA_W  registered read of r[xsel].
- y  out  DATA_W  registered read of r[ysel].
- pc  out  DATA_W  combinational copy of r[PC_IDX].
- loop_taken  out  1  one-cycle pulse when a loop branch is taken.
- loop_zero  out  1  registered flag, high when the loop counter is zero.

Behaviour:
- Reset: on a falling edge with reset==0, all registers become 0, x=0, y=0, loop_taken=0, loop_zero=1. Reset overrides every other input on that edge.
- Reads: on each falling edge, x<=r[xsel] and y<=r[ysel], using pre-edge register contents. This is read-before-write; there is no bypass. Latency is one edge. xsel==ysel is legal, and both outputs then carry the same value.
- Lane write: wr_lo and wr_hi act independently. With both set, the whole word is written. With neither set, no z write occurs.
- Loop step (loopen=1):
  - cnt_next = r[LCNT_IDX]-1 modulo 2**DATA_W, so 0 wraps to all-ones.
  - If cnt_next!=0: pc_next=r[LADR_IDX] and loop_taken<=1.
  - Otherwise: pc_next follows the pcen rule and loop_taken<=0.
- PC rule (when no branch is taken): pc_next = r[PC_IDX]+1 modulo 2**DATA_W if pcen, else unchanged. A taken loop branch overrides pcen.
- Write priority: a z lane write to PC_IDX or LCNT_IDX wins over pc_next/cnt_next, for that lane only. The other lane takes the auto-updated value. Example: wr_lo to the PC plus a taken branch gives {r13 high half, z low half}.
- loop_zero is registered from the post-edge value of r[LCNT_IDX] (next-state ==0), so it tracks both loop decrements and z writes.
- loop_taken is 0 on every edge without a taken branch, so it is a single-cycle pulse.
- zsel==LADR_IDX on the same edge as a taken branch: the branch uses the old r13, and the new value lands in r13.
- Registers are updated only by reset, lane writes, the PC rule and the loop step; no other mechanism changes them.

Test Plan:
- Reset: drive reset=0 for 2 edges after random writes -> x=y=pc=0, loop_zero=1, loop_taken=0. Then read all 16 registers -> all 0.
- Lane write: write z=16'hA5C3 to r3 with wr_lo only, then z=16'h7E00 with wr_hi only; read xsel=3 -> 16'h7EC3. On the write edge with ysel=3, y shows the pre-write value.
- PC increment: PC=16'hFFFF, pcen=1 -> pc=16'h0000 next edge. pcen=1 with wr_hi, z=16'h1200 -> pc=16'h1201 (low lane auto +1 = 01, high lane from z).
- Loop: r12=3, r13=16'h0040, PC=16'h0050, loopen=1 and pcen=1 for 3 edges -> loop_taken pulses 1,1,0; pc=0040,0040,0041; r12 ends 0; loop_zero=1 after the third edge.
- Loop wrap and priority: r12=0, loopen=1 -> r12=16'hFFFF, branch taken, loop_zero=0. Taken branch plus zsel=15 wr_lo, z=16'h0099, r13=16'h1234 -> pc=16'h1299.
- Reset mid-loop: assert reset while loopen=1, r12=5 -> r12=0, loop_taken=0, pc=0 on that edge.

Source files
------------

// File: rtl/regfile_loop_pc_param.sv
// Parametrised general register file: two registered read ports, one lane-masked
// write port, built-in PC auto-increment and hardware loop step. Falling-edge state.
module regfile_loop_pc_param #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned SEL_W    = 4,
  parameter int unsigned PC_IDX   = 15,
  parameter int unsigned LCNT_IDX = 12,
  parameter int unsigned LADR_IDX = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] z,
  input  logic [SEL_W-1:0]  zsel,
  input  logic              wr_lo,
  input  logic              wr_hi,
  input  logic [SEL_W-1:0]  xsel,
  input  logic [SEL_W-1:0]  ysel,
  input  logic              pcen,
  input  logic              loopen,
  output logic [DATA_W-1:0] x,
  output logic [DATA_W-1:0] y,
  output logic [DATA_W-1:0] pc,
  output logic              loop_taken,
  output logic              loop_zero
);

  localparam int unsigned NUM_REGS = 2 ** SEL_W;
  localparam int unsigned HALF_W   = DATA_W / 2;
  localparam logic [SEL_W-1:0] PC_SEL   = SEL_W'(PC_IDX);
  localparam logic [SEL_W-1:0] LCNT_SEL = SEL_W'(LCNT_IDX);
  localparam logic [SEL_W-1:0] LADR_SEL = SEL_W'(LADR_IDX);

  logic [DATA_W-1:0] regs      [NUM_REGS];
  logic [DATA_W-1:0] regs_next [NUM_REGS];
  logic [DATA_W-1:0] cnt_dec;
  logic [DATA_W-1:0] pc_auto;
  logic [DATA_W-1:0] lane_mask;
  logic              branch;

  // Auto-updates first, then the z lane write overrides per half-word.
  always_comb begin
    cnt_dec   = regs[LCNT_SEL] - DATA_W'(1);
    branch    = loopen && (cnt_dec != '0);
    pc_auto   = regs[PC_SEL];
    lane_mask = {{HALF_W{wr_hi}}, {HALF_W{wr_lo}}};
    if (branch) begin
      pc_auto = regs[LADR_SEL];
    end else if (pcen) begin
      pc_auto = regs[PC_SEL] + DATA_W'(1);
    end
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      regs_next[SEL_W'(i)] = regs[SEL_W'(i)];
      if (SEL_W'(i) == PC_SEL) begin
        regs_next[SEL_W'(i)] = pc_auto;
      end
      if (SEL_W'(i) == LCNT_SEL && loopen) begin
        regs_next[SEL_W'(i)] = cnt_dec;
      end
      if (SEL_W'(i) == zsel) begin
        regs_next[SEL_W'(i)] = (regs_next[SEL_W'(i)] & ~lane_mask) | (z & lane_mask);
      end
    end
  end

  // Reads use pre-edge contents: no write-to-read bypass.
  always_ff @(negedge clk) begin
    if (!reset) begin
      regs       <= '{default: '0};
      x          <= '0;
      y          <= '0;
      loop_taken <= 1'b0;
      loop_zero  <= 1'b1;
    end else begin
      regs       <= regs_next;
      x          <= regs[xsel];
      y          <= regs[ysel];
      loop_taken <= branch;
      loop_zero  <= (regs_next[LCNT_SEL] == '0);
    end
  end

  assign pc = regs[PC_SEL];

endmodule

// File: tb/tb_regfile_loop_pc_param.sv
// Scoreboard bench for regfile_loop_pc_param: a spec-level model pushes expected
// outputs per edge; a monitor on the rising edge pops and compares.
module tb_regfile_loop_pc_param;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] z;
  logic [3:0]  zsel, xsel, ysel;
  logic        wr_lo, wr_hi, pcen, loopen;
  logic [15:0] x, y, pc;
  logic        loop_taken, loop_zero;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] pc;
    logic        taken;
    logic        zero;
  } exp_t;

  exp_t        q[$];
  logic [15:0] m[16];
  int          total  = 0;
  int          passed = 0;

  regfile_loop_pc_param dut (
    .clk(clk), .reset(reset), .z(z), .zsel(zsel), .wr_lo(wr_lo), .wr_hi(wr_hi),
    .xsel(xsel), .ysel(ysel), .pcen(pcen), .loopen(loopen),
    .x(x), .y(y), .pc(pc), .loop_taken(loop_taken), .loop_zero(loop_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // State changes on the falling edge; outputs are sampled on the rising edge.
  always @(posedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("x", x, e.x);
      check("y", y, e.y);
      check("pc", pc, e.pc);
      check("loop_taken", 16'(loop_taken), 16'(e.taken));
      check("loop_zero", 16'(loop_zero), 16'(e.zero));
    end
  end

  // Drive one edge's inputs and predict the post-edge outputs.
  task automatic step(input logic rst, input logic [15:0] zz, input logic [3:0] zs,
                      input logic lo, input logic hi, input logic [3:0] xs,
                      input logic [3:0] ys, input logic pe, input logic le);
    exp_t        e;
    logic [15:0] nm[16];
    logic [15:0] mask;
    logic        taken;
    @(posedge clk);
    #1;
    reset = rst; z = zz; zsel = zs; wr_lo = lo; wr_hi = hi;
    xsel = xs; ysel = ys; pcen = pe; loopen = le;
    taken = 1'b0;
    if (!rst) begin
      for (int i = 0; i < 16; i++) m[i] = 16'h0000;
      e.x = 16'h0000; e.y = 16'h0000; e.zero = 1'b1;
    end else begin
      e.x = m[xs];
      e.y = m[ys];
      nm = m;
      if (le) begin
        nm[12] = m[12] - 16'd1;
        taken  = (nm[12] != 16'd0);
      end
      nm[15] = taken ? m[13] : (pe ? m[15] + 16'd1 : m[15]);
      mask = (hi ? 16'hFF00 : 16'h0000) | (lo ? 16'h00FF : 16'h0000);
      nm[zs] = (nm[zs] & ~mask) | (zz & mask);
      m = nm;
      e.zero = (m[12] == 16'd0);
    end
    e.taken = taken;
    e.pc = m[15];
    q.push_back(e);
  endtask

  task automatic wr(input logic [3:0] sel, input logic [15:0] data);
    step(1'b1, data, sel, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic idle(input logic [3:0] xs, input logic [3:0] ys);
    step(1'b1, 16'h0000, 4'd0, 1'b0, 1'b0, xs, ys, 1'b0, 1'b0);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; z = '0; zsel = '0; wr_lo = 1'b0; wr_hi = 1'b0;
    xsel = '0; ysel = '0; pcen = 1'b0; loopen = 1'b0;
    step(1'b0, 16'h0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);

    // Reset after random writes
    for (int i = 0; i < 20; i++) wr(4'($urandom), 16'($urandom));
    step(1'b0, 16'hFFFF, 4'd15, 1'b1, 1'b1, 4'd15, 4'd3, 1'b1, 1'b1);
    step(1'b0, 16'hFFFF, 4'd12, 1'b1, 1'b1, 4'd12, 4'd13, 1'b1, 1'b1);
    settle();
    check("reset_pc", pc, 16'h0000);
    check("reset_zero", 16'(loop_zero), 16'h0001);
    for (int i = 0; i < 16; i++) idle(4'(i), 4'(15 - i));

    // Lane writes; y shows the pre-write value on the write edge
    step(1'b1, 16'hA5C3, 4'd3, 1'b1, 1'b0, 4'd0, 4'd3, 1'b0, 1'b0);
    step(1'b1, 16'h7E00, 4'd3, 1'b0, 1'b1, 4'd0, 4'd3, 1'b0, 1'b0);
    settle();
    check("lane_y_prewrite", y, 16'h00C3);
    idle(4'd3, 4'd3);
    settle();
    check("lane_x", x, 16'h7EC3);

    // PC increment wrap and high-lane override
    wr(4'd15, 16'hFFFF);
    step(1'b1, 16'h0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
    settle();
    check("pc_wrap", pc, 16'h0000);
    step(1'b1, 16'h1200, 4'd15, 1'b0, 1'b1, 4'd0, 4'd0, 1'b1, 1'b0);
    settle();
    check("pc_hi_lane", pc, 16'h1201);

    // Hardware loop: three iterations from count 3
    wr(4'd12, 16'd3);
    wr(4'd13, 16'h0040);
    wr(4'd15, 16'h0050);
    step(1'b1, 16'h0, 4'd0, 1'b0, 1'b0, 4'd12, 4'd13, 1'b1, 1'b1);
    settle();
    check("loop1_taken", 16'(loop_taken), 16'h0001);
    check("loop1_pc", pc, 16'h0040);
    step(1'b1, 16'h0, 4'd0, 1'b0, 1'b0, 4'd12, 4'd13, 1'b1, 1'b1);
    settle();
    check("loop2_taken", 16'(loop_taken), 16'h0001);
    check("loop2_pc", pc, 16'h0040);
    step(1'b1, 16'h0, 4'd0, 1'b0, 1'b0, 4'd12, 4'd13, 1'b1, 1'b1);
    settle();
    check("loop3_taken", 16'(loop_taken), 16'h0000);
    check("loop3_pc", pc, 16'h0041);
    check("loop3_zero", 16'(loop_zero), 16'h0001);
    idle(4'd12, 4'd15);
    settle();
    check("loop_cnt_end", x, 16'h0000);

    // Counter wrap from zero, then lane priority over a taken branch
    wr(4'd13, 16'h1234);
    wr(4'd12, 16'h0000);
    step(1'b1, 16'h0, 4'd0, 1'b0, 1'b0, 4'd12, 4'd12, 1'b0, 1'b1);
    settle();
    check("wrap_zero", 16'(loop_zero), 16'h0000);
    check("wrap_taken", 16'(loop_taken), 16'h0001);
    step(1'b1, 16'h0099, 4'd15, 1'b1, 1'b0, 4'd12, 4'd0, 1'b1, 1'b1);
    settle();
    check("prio_pc", pc, 16'h1299);
    check("wrap_cnt", x, 16'hFFFF);
    // Write to loop address on a taken branch: branch uses the old value
    step(1'b1, 16'h5555, 4'd13, 1'b1, 1'b1, 4'd13, 4'd12, 1'b0, 1'b1);
    settle();
    check("ladr_old_pc", pc, 16'h1234);
    idle(4'd13, 4'd12);

    // Reset mid-loop
    wr(4'd12, 16'd5);
    step(1'b0, 16'h0, 4'd0, 1'b0, 1'b0, 4'd12, 4'd13, 1'b1, 1'b1);
    settle();
    check("midloop_pc", pc, 16'h0000);
    check("midloop_taken", 16'(loop_taken), 16'h0000);

    // Randomised traffic, biased toward the loop/PC registers
    for (int i = 0; i < 600; i++) begin
      logic [3:0] zs;
      zs = ($urandom_range(0, 1) == 0) ? 4'(12 + $urandom_range(0, 3)) : 4'($urandom);
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 4)) : 16'($urandom),
           zs, 1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom),
           1'($urandom), ($urandom_range(0, 2) != 0));
    end

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #1;
    total++;
    if (q.size() == 0) passed++;
    else $display("FAIL drain: %0d expectations left, expected 0", q.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
